// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative MIPS MULT/MULTU/DIV/DIVU sequencer and HI/LO owner. An op is busy for 33 cycles; MD_EARLY_OUT_EN ends MUL early.
// Backpressure: md_stall holds decode while busy and ID needs HI/LO or the unit. Starts, MTHI and MTLO issued while busy are ignored.
module mult_div_ctrl #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_read,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    localparam int CW = $clog2(ITERS + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0] r_prod;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_dvsr;
    logic [31:0] r_rs_cap;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_is_div;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [63:0] w_mul_sum;
    logic [31:0] w_mplier_nxt;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_fits;
    logic [63:0] w_prod_fix;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign w_signed     = ~md_op[0];
    assign w_abs_rs     = (w_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    assign w_abs_rt     = (w_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
    assign w_mul_sum    = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_mplier_nxt = r_mplier >> 1;

    // rem < divisor keeps a successful trial below 2^32, so bit 32 flags a borrow.
    assign w_shift      = {r_rem, r_quot[31]};
    assign w_trial      = w_shift - {1'b0, r_dvsr};
    assign w_fits       = ~w_trial[32];
    assign w_prod_fix   = r_neg_q ? (~r_prod + 64'd1) : r_prod;

    assign md_busy  = (r_state != S_IDLE);
    assign md_stall = md_busy & (md_start | md_read | hi_we | lo_we);
    assign hi       = r_hi;
    assign lo       = r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvsr   <= '0;
            r_rs_cap <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (md_start) begin
                        r_neg_q  <= w_signed & (rs_data[31] ^ rt_data[31]);
                        r_neg_r  <= w_signed & rs_data[31];
                        r_is_div <= md_op[1];
                        r_div0   <= (rt_data == 32'd0);
                        r_rs_cap <= rs_data;
                        r_cnt    <= CW'(ITERS);
                        r_prod   <= '0;
                        r_mcand  <= {32'd0, w_abs_rs};
                        r_mplier <= w_abs_rt;
                        r_rem    <= '0;
                        r_quot   <= w_abs_rs;
                        r_dvsr   <= w_abs_rt;
                        if (md_op[1])
                            r_state <= S_DIV;
                        else if (EARLY_OUT && (w_abs_rt == 32'd0))
                            r_state <= S_FIX;
                        else
                            r_state <= S_MUL;
                    end else begin
                        if (hi_we) r_hi <= rs_data;
                        if (lo_we) r_lo <= rs_data;
                    end
                end
                S_MUL: begin
                    r_prod   <= w_mul_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt - CW'(1);
                    if ((r_cnt == CW'(1)) || (EARLY_OUT && (w_mplier_nxt == 32'd0)))
                        r_state <= S_FIX;
                end
                S_DIV: begin
                    r_rem  <= w_fits ? w_trial[31:0] : w_shift[31:0];
                    r_quot <= {r_quot[30:0], w_fits};
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_div0) begin
                        r_lo <= 32'hFFFF_FFFF;
                        r_hi <= r_rs_cap;
                    end else begin
                        r_lo <= r_neg_q ? (~r_quot + 32'd1) : r_quot;
                        r_hi <= r_neg_r ? (~r_rem + 32'd1) : r_rem;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed vector table, random ops against an arithmetic model, and stall/reset sequences.
module tb_mult_div_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_read;
    logic        hi_we;
    logic        lo_we;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    mult_div_ctrl #(.ITERS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .md_read  (md_read),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ehi, output logic [31:0] elo);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00) begin
            p = sa * sb;
            {ehi, elo} = p;
        end else if (op == 2'b01) begin
            p = {32'd0, a} * {32'd0, b};
            {ehi, elo} = p;
        end else if (b == 32'd0) begin
            elo = 32'hFFFF_FFFF;
            ehi = a;
        end else begin
            if (op == 2'b10) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = {32'd0, a} / {32'd0, b};
                r = {32'd0, a} % {32'd0, b};
            end
            elo = q[31:0];
            ehi = r[31:0];
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] mag;
        int          top;
        if (op[1] || !EARLY) return 33;
        mag = (!op[0] && b[31]) ? -b : b;
        if (mag == 32'd0) return 1;
        top = 0;
        for (int i = 0; i < 32; i++)
            if (mag[i]) top = i;
        return top + 2;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        md_start = 1'b1;
        md_op    = op;
        rs_data  = a;
        rt_data  = b;
        tick();
        md_start = 1'b0;
        md_op    = 2'b00;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        lat      = 0;
        while (md_busy && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        run_op(op, a, b, lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat(op, b)));
        check({name, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, elo});
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 20));
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4] = '{2'b01, 32'd5,         32'd3,        32'd0,         32'd15};
        vecs[5] = '{2'b01, 32'd9,         32'd0,        32'd0,         32'd0};
        vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9] = '{2'b11, 32'd100,       32'd7,        32'd2,         32'd14};

        rst = 1'b1; md_start = 1'b0; md_op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
        md_read = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        tick();
        tick();
        check("reset_busy", {63'd0, md_busy}, 64'd0);
        check("reset_stall", {63'd0, md_stall}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

        // MTHI alone, then MTHI+MTLO together, with an idle MFHI that must not stall.
        hi_we = 1'b1; rs_data = 32'h1234_5678; md_read = 1'b1;
        #1;
        check("idle_read_stall", {63'd0, md_stall}, 64'd0);
        tick();
        hi_we = 1'b0; md_read = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'hAAAA_5555;
        tick();
        hi_we = 1'b0; lo_we = 1'b0; rs_data = 32'd0;
        check("mt_both_hi", {32'd0, hi}, 64'hAAAA_5555);
        check("mt_both_lo", {32'd0, lo}, 64'hAAAA_5555);

        // MULTU with MFHI/MFLO from cycle 5 plus a replayed start and MTHI mid-op.
        md_start = 1'b1; md_op = 2'b01; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
        tick();
        md_start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            md_read  = (k >= 5);
            md_start = (k == 10);
            hi_we    = (k == 12);
            md_op    = 2'b00;
            rs_data  = (k == 10 || k == 12) ? 32'h0BAD_0BAD : 32'd0;
            rt_data  = (k == 10) ? 32'd3 : 32'd0;
            #1;
            check($sformatf("stall_c%0d", k), {63'd0, md_stall}, {63'd0, (k >= 5 && k <= 33)});
            if (k <= 33) begin
                check($sformatf("busy_c%0d", k), {63'd0, md_busy}, 64'd1);
                check($sformatf("hold_c%0d", k), {hi, lo}, {32'hAAAA_5555, 32'hAAAA_5555});
            end else begin
                check("busy_fall", {63'd0, md_busy}, 64'd0);
                check("stall_result", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
            end
            @(posedge clk);
            #1;
        end
        md_read = 1'b0; hi_we = 1'b0; md_start = 1'b0; rs_data = 32'd0; rt_data = 32'd0;
        tick();
        check("no_replay_busy", {63'd0, md_busy}, 64'd0);

        // Reset in the middle of a divide.
        md_start = 1'b1; md_op = 2'b10; rs_data = 32'd1000; rt_data = 32'd7;
        tick();
        md_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {63'd0, md_busy}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        do_op("after_rst", 2'b10, 32'd1000, 32'd7, 32'd6, 32'd142);

        for (int n = 0; n < 50; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = rand_operand();
            b  = rand_operand();
            model(op, a, b, ehi, elo);
            do_op($sformatf("rnd%0d_op%0d_%h_%h", n, op, a, b), op, a, b, ehi, elo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
